// File: rtl/tlu_emulator.sv
// TLU emulator: issues triggers (on request or periodically), runs the trigger/busy
// handshake with tlu_controller and returns the trigger ID serially, LSB-first.
module tlu_emulator #(
    parameter int unsigned TRIGGER_ID_WIDTH = 15,
    parameter int unsigned BUSY_TIMEOUT     = 1024,
    parameter int unsigned RESET_LEN        = 8
) (
    input  logic                        BUS_CLK,
    input  logic                        BUS_RST,
    input  logic                        ENABLE,
    input  logic                        TRIG_REQ,
    input  logic [15:0]                 AUTO_PERIOD,
    input  logic                        RESET_REQ,
    input  logic                        TLU_CLOCK,
    input  logic                        TLU_BUSY,
    output logic                        TLU_TRIGGER,
    output logic                        TLU_RESET,
    output logic [TRIGGER_ID_WIDTH-1:0] TRIGGER_ID,
    output logic [15:0]                 VETO_COUNT,
    output logic                        TIMEOUT_ERR,
    output logic                        ACTIVE
);

    localparam int unsigned TO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned RL_W = $clog2(RESET_LEN + 1);
    localparam int unsigned SR_W = TRIGGER_ID_WIDTH + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRIG  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] RST   = 2'd3;

    logic [1:0]                  state, state_nxt;
    logic                        clk_ff1, clk_s, clk_hist;
    logic                        busy_ff1, busy_s;
    logic [TO_W-1:0]             to_cnt, to_cnt_nxt;
    logic [RL_W-1:0]             rl_cnt, rl_cnt_nxt;
    logic [SR_W-1:0]             sr, sr_nxt;
    logic [15:0]                 auto_cnt, auto_cnt_nxt;
    logic                        reset_pend, reset_pend_nxt;
    logic                        trig_nxt, tlu_reset_nxt, timeout_nxt;
    logic [TRIGGER_ID_WIDTH-1:0] id_nxt;
    logic [15:0]                 veto_nxt;
    logic                        clk_rise_c, auto_tick_c, req_c, pend_c, accept_c;

    // Double-flop synchronizers for the controller-side asynchronous lines
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            clk_ff1  <= 1'b0;
            clk_s    <= 1'b0;
            clk_hist <= 1'b0;
            busy_ff1 <= 1'b0;
            busy_s   <= 1'b0;
        end else begin
            clk_ff1  <= TLU_CLOCK;
            clk_s    <= clk_ff1;
            clk_hist <= clk_s;
            busy_ff1 <= TLU_BUSY;
            busy_s   <= busy_ff1;
        end
    end

    assign clk_rise_c = clk_s & ~clk_hist;
    assign pend_c     = reset_pend | RESET_REQ;
    assign req_c      = ENABLE & (TRIG_REQ | auto_tick_c);

    // Auto-trigger divider: ticks on the wrap back to zero
    always_comb begin
        auto_cnt_nxt = auto_cnt + 16'd1;
        auto_tick_c  = 1'b0;
        if ((AUTO_PERIOD == 16'd0) || !ENABLE) begin
            auto_cnt_nxt = 16'd0;
        end else if (auto_cnt >= AUTO_PERIOD - 16'd1) begin
            auto_cnt_nxt = 16'd0;
            auto_tick_c  = 1'b1;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt      = state;
        to_cnt_nxt     = to_cnt;
        rl_cnt_nxt     = rl_cnt;
        sr_nxt         = sr;
        id_nxt         = TRIGGER_ID;
        veto_nxt       = VETO_COUNT;
        reset_pend_nxt = pend_c;
        trig_nxt       = 1'b0;
        tlu_reset_nxt  = 1'b0;
        timeout_nxt    = 1'b0;
        accept_c       = 1'b0;

        case (state)
            IDLE: begin
                if (pend_c) begin
                    state_nxt      = RST;
                    rl_cnt_nxt     = '0;
                    id_nxt         = '0;
                    tlu_reset_nxt  = 1'b1;
                    reset_pend_nxt = 1'b0;
                end else if (req_c && !clk_s) begin
                    state_nxt  = TRIG;
                    to_cnt_nxt = '0;
                    trig_nxt   = 1'b1;
                    accept_c   = 1'b1;
                end
            end
            TRIG: begin
                if (busy_s) begin
                    // Leading zero goes out first, ID follows from bit 0
                    state_nxt = SHIFT;
                    sr_nxt    = {TRIGGER_ID, 1'b0};
                end else if (to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                    trig_nxt   = 1'b1;
                end
            end
            SHIFT: begin
                // Busy release wins over a coincident clock edge
                if (!busy_s) begin
                    state_nxt = IDLE;
                    id_nxt    = TRIGGER_ID + TRIGGER_ID_WIDTH'(1);
                end else if (clk_rise_c) begin
                    sr_nxt   = sr >> 1;
                    trig_nxt = sr[1];
                end else begin
                    trig_nxt = sr[0];
                end
            end
            default: begin
                if (rl_cnt == RL_W'(RESET_LEN - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    rl_cnt_nxt    = rl_cnt + RL_W'(1);
                    tlu_reset_nxt = 1'b1;
                end
            end
        endcase

        if (req_c && !accept_c && (VETO_COUNT != 16'hFFFF)) begin
            veto_nxt = VETO_COUNT + 16'd1;
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state       <= IDLE;
            to_cnt      <= '0;
            rl_cnt      <= '0;
            sr          <= '0;
            auto_cnt    <= 16'd0;
            reset_pend  <= 1'b0;
            TLU_TRIGGER <= 1'b0;
            TLU_RESET   <= 1'b0;
            TRIGGER_ID  <= '0;
            VETO_COUNT  <= 16'd0;
            TIMEOUT_ERR <= 1'b0;
            ACTIVE      <= 1'b0;
        end else begin
            state       <= state_nxt;
            to_cnt      <= to_cnt_nxt;
            rl_cnt      <= rl_cnt_nxt;
            sr          <= sr_nxt;
            auto_cnt    <= auto_cnt_nxt;
            reset_pend  <= reset_pend_nxt;
            TLU_TRIGGER <= trig_nxt;
            TLU_RESET   <= tlu_reset_nxt;
            TRIGGER_ID  <= id_nxt;
            VETO_COUNT  <= veto_nxt;
            TIMEOUT_ERR <= timeout_nxt;
            ACTIVE      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_tlu_emulator.sv
// Directed bench for tlu_emulator: cycle table from reset, then controller-BFM sequences.
module tb_tlu_emulator;

    localparam int unsigned W = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic          BUS_CLK = 1'b0;
    logic          BUS_RST = 1'b1;
    logic          ENABLE = 1'b0;
    logic          TRIG_REQ = 1'b0;
    logic [15:0]   AUTO_PERIOD = 16'd0;
    logic          RESET_REQ = 1'b0;
    logic          TLU_CLOCK = 1'b0;
    logic          TLU_BUSY = 1'b0;
    logic          TLU_TRIGGER;
    logic          TLU_RESET;
    logic [W-1:0]  TRIGGER_ID;
    logic [15:0]   VETO_COUNT;
    logic          TIMEOUT_ERR;
    logic          ACTIVE;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct packed {
        logic        en, req, rreq, tclk, busy;
        logic        trig, trst, act;
        logic [15:0] veto;
        logic [3:0]  id;
    } vec_t;

    vec_t tbl [26];

    tlu_emulator #(
        .TRIGGER_ID_WIDTH(W),
        .BUSY_TIMEOUT(32),
        .RESET_LEN(8)
    ) dut (
        .BUS_CLK(BUS_CLK),
        .BUS_RST(BUS_RST),
        .ENABLE(ENABLE),
        .TRIG_REQ(TRIG_REQ),
        .AUTO_PERIOD(AUTO_PERIOD),
        .RESET_REQ(RESET_REQ),
        .TLU_CLOCK(TLU_CLOCK),
        .TLU_BUSY(TLU_BUSY),
        .TLU_TRIGGER(TLU_TRIGGER),
        .TLU_RESET(TLU_RESET),
        .TRIGGER_ID(TRIGGER_ID),
        .VETO_COUNT(VETO_COUNT),
        .TIMEOUT_ERR(TIMEOUT_ERR),
        .ACTIVE(ACTIVE)
    );

    always #5 BUS_CLK = ~BUS_CLK;
    always @(posedge BUS_CLK) cyc <= cyc + 1;

    function automatic vec_t mk(input logic en, req, rreq, tclk, busy,
                                input logic trig, trst, act,
                                input logic [15:0] veto, input logic [3:0] id);
        vec_t v;
        v = {en, req, rreq, tclk, busy, trig, trst, act, veto, id};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_trig(input int limit);
        int n = 0;
        while (TLU_TRIGGER !== 1'b1 && n < limit) begin
            @(negedge BUS_CLK);
            n++;
        end
        check("trig_seen", 32'(TLU_TRIGGER), 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (ACTIVE !== 1'b0 && n < limit) begin
            @(negedge BUS_CLK);
            n++;
        end
        check("idle_seen", 32'(ACTIVE), 32'd0);
    endtask

    task automatic pulse_req();
        TRIG_REQ = 1'b1;
        @(negedge BUS_CLK);
        TRIG_REQ = 1'b0;
    endtask

    // Controller model: busy after 5 cycles, samples the line then issues a clock pulse
    task automatic handshake(input int nclk, output logic [15:0] bits);
        bits = '0;
        wait_trig(50);
        repeat (5) @(negedge BUS_CLK);
        TLU_BUSY = 1'b1;
        repeat (4) @(negedge BUS_CLK);
        for (int i = 0; i < nclk; i++) begin
            bits[i] = TLU_TRIGGER;
            TLU_CLOCK = 1'b1;
            repeat (3) @(negedge BUS_CLK);
            TLU_CLOCK = 1'b0;
            repeat (3) @(negedge BUS_CLK);
        end
        TLU_BUSY = 1'b0;
        wait_idle(20);
    endtask

    initial begin
        logic [15:0] bits;
        logic [3:0]  exp_id;
        int          exp_veto;
        int          n;
        int          te_cnt;
        int          t_trig [3];

        //        en req rrq clk bsy | trg rst act veto id
        tbl[0]  = mk(H, L, L, L, L,   L, L, L, 16'd0, 4'd0);
        tbl[1]  = mk(H, H, L, L, L,   H, L, H, 16'd0, 4'd0);
        tbl[2]  = mk(H, H, L, L, L,   H, L, H, 16'd1, 4'd0);
        tbl[3]  = mk(H, L, L, L, H,   H, L, H, 16'd1, 4'd0);
        tbl[4]  = mk(H, L, L, L, H,   H, L, H, 16'd1, 4'd0);
        tbl[5]  = mk(H, L, L, L, H,   L, L, H, 16'd1, 4'd0);
        tbl[6]  = mk(H, L, L, H, H,   L, L, H, 16'd1, 4'd0);
        tbl[7]  = mk(H, L, L, H, H,   L, L, H, 16'd1, 4'd0);
        tbl[8]  = mk(H, H, L, H, H,   L, L, H, 16'd2, 4'd0);
        tbl[9]  = mk(H, L, L, L, L,   L, L, H, 16'd2, 4'd0);
        tbl[10] = mk(H, L, L, L, L,   L, L, H, 16'd2, 4'd0);
        tbl[11] = mk(H, L, L, L, L,   L, L, L, 16'd2, 4'd1);
        tbl[12] = mk(H, L, L, H, L,   L, L, L, 16'd2, 4'd1);
        tbl[13] = mk(H, L, L, H, L,   L, L, L, 16'd2, 4'd1);
        tbl[14] = mk(H, H, L, H, L,   L, L, L, 16'd3, 4'd1);
        tbl[15] = mk(L, H, L, L, L,   L, L, L, 16'd3, 4'd1);
        tbl[16] = mk(L, H, L, L, L,   L, L, L, 16'd3, 4'd1);
        tbl[17] = mk(H, L, H, L, L,   L, H, H, 16'd3, 4'd0);
        tbl[18] = mk(H, H, L, L, L,   L, H, H, 16'd4, 4'd0);
        for (int i = 19; i < 25; i++) tbl[i] = mk(H, L, L, L, L, L, H, H, 16'd4, 4'd0);
        tbl[25] = mk(H, L, L, L, L,   L, L, L, 16'd4, 4'd0);

        #2;
        check("reset_outputs", 32'({TLU_TRIGGER, TLU_RESET, TIMEOUT_ERR, ACTIVE, VETO_COUNT, TRIGGER_ID}), 32'd0);
        repeat (3) @(negedge BUS_CLK);
        BUS_RST = 1'b0;

        // Cycle table: drive at negedge, check one edge later
        for (int i = 0; i < 26; i++) begin
            ENABLE    = tbl[i].en;
            TRIG_REQ  = tbl[i].req;
            RESET_REQ = tbl[i].rreq;
            TLU_CLOCK = tbl[i].tclk;
            TLU_BUSY  = tbl[i].busy;
            @(negedge BUS_CLK);
            check($sformatf("vec%0d", i),
                  32'({TLU_TRIGGER, TLU_RESET, ACTIVE, VETO_COUNT, TRIGGER_ID}),
                  32'({tbl[i].trig, tbl[i].trst, tbl[i].act, tbl[i].veto, tbl[i].id}));
        end
        ENABLE = 1'b1; TRIG_REQ = 1'b0; RESET_REQ = 1'b0; TLU_CLOCK = 1'b0; TLU_BUSY = 1'b0;
        exp_veto = 4;

        // Single handshake with 16 clocks
        pulse_req();
        handshake(16, bits);
        check("single_serial", 32'(bits), 32'd0);
        check("single_id_after", 32'(TRIGGER_ID), 32'd1);

        // Controller-issued reset returns ID to zero
        RESET_REQ = 1'b1;
        @(negedge BUS_CLK);
        RESET_REQ = 1'b0;
        check("rreq_reset_high", 32'({TLU_RESET, TRIGGER_ID}), 32'({1'b1, 4'd0}));
        wait_idle(20);

        // ID sequence across the 4-bit wrap
        for (int k = 0; k < 17; k++) begin
            exp_id = 4'(k);
            pulse_req();
            handshake(16, bits);
            check($sformatf("wrap_serial%0d", k), 32'(bits), 32'({11'd0, exp_id, 1'b0}));
        end
        check("wrap_id_end", 32'(TRIGGER_ID), 32'd1);

        for (int k = 1; k < 5; k++) begin
            exp_id = 4'(k);
            pulse_req();
            handshake(6, bits);
            check($sformatf("pre_serial%0d", k), 32'(bits), 32'({11'd0, exp_id, 1'b0}));
        end
        check("pre_defer_id", 32'(TRIGGER_ID), 32'd5);

        // Deferred reset and vetoed requests during SHIFT
        pulse_req();
        wait_trig(50);
        TLU_BUSY = 1'b1;
        repeat (4) @(negedge BUS_CLK);
        RESET_REQ = 1'b1;
        @(negedge BUS_CLK);
        RESET_REQ = 1'b0;
        TRIG_REQ = 1'b1;
        repeat (3) @(negedge BUS_CLK);
        TRIG_REQ = 1'b0;
        exp_veto += 3;
        for (int i = 0; i < 2; i++) begin
            TLU_CLOCK = 1'b1;
            repeat (3) @(negedge BUS_CLK);
            TLU_CLOCK = 1'b0;
            repeat (3) @(negedge BUS_CLK);
        end
        check("defer_no_reset", 32'({ACTIVE, TLU_RESET}), 32'({1'b1, 1'b0}));
        check("defer_veto", 32'(VETO_COUNT), 32'(exp_veto));
        TLU_BUSY = 1'b0;
        n = 0;
        while (TRIGGER_ID == 4'd5 && n < 20) begin
            @(negedge BUS_CLK);
            n++;
        end
        check("defer_id_inc", 32'({TRIGGER_ID, TLU_RESET}), 32'({4'd6, 1'b0}));
        @(negedge BUS_CLK);
        check("defer_reset_start", 32'({TRIGGER_ID, TLU_RESET}), 32'({4'd0, 1'b1}));
        n = 0;
        while (TLU_RESET === 1'b1 && n < 50) begin
            n++;
            @(negedge BUS_CLK);
        end
        check("defer_reset_len", 32'(n), 32'd8);
        wait_idle(20);
        pulse_req();
        handshake(16, bits);
        check("post_reset_serial", 32'(bits), 32'd0);
        check("post_reset_id", 32'(TRIGGER_ID), 32'd1);

        // Busy timeout: controller never answers
        pulse_req();
        n = 0;
        te_cnt = 0;
        while (TLU_TRIGGER === 1'b1 && n < 100) begin
            n++;
            if (TIMEOUT_ERR === 1'b1) te_cnt++;
            @(negedge BUS_CLK);
        end
        check("timeout_trig_len", 32'(n), 32'd32);
        check("timeout_pulse_now", 32'(TIMEOUT_ERR), 32'd1);
        te_cnt += (TIMEOUT_ERR === 1'b1) ? 1 : 0;
        @(negedge BUS_CLK);
        te_cnt += (TIMEOUT_ERR === 1'b1) ? 1 : 0;
        check("timeout_pulse_count", 32'(te_cnt), 32'd1);
        check("timeout_after", 32'({ACTIVE, TRIGGER_ID}), 32'({1'b0, 4'd1}));

        // Auto mode with a fast controller; last trigger left in SHIFT
        AUTO_PERIOD = 16'd100;
        for (int k = 0; k < 3; k++) begin
            wait_trig(300);
            t_trig[k] = cyc;
            TLU_BUSY = 1'b1;
            if (k < 2) begin
                repeat (6) @(negedge BUS_CLK);
                TLU_BUSY = 1'b0;
                wait_idle(20);
            end
        end
        check("auto_pitch1", 32'(t_trig[1] - t_trig[0]), 32'd100);
        check("auto_pitch2", 32'(t_trig[2] - t_trig[1]), 32'd100);
        repeat (5) @(negedge BUS_CLK);
        check("auto_in_shift", 32'({ACTIVE, TRIGGER_ID, VETO_COUNT}), 32'({1'b1, 4'd3, 16'(exp_veto)}));

        // Asynchronous reset in the middle of a readout
        BUS_RST = 1'b1;
        #1;
        check("async_reset", 32'({TLU_TRIGGER, TLU_RESET, TIMEOUT_ERR, ACTIVE, VETO_COUNT, TRIGGER_ID}), 32'd0);
        AUTO_PERIOD = 16'd0;
        TLU_BUSY = 1'b0;
        @(negedge BUS_CLK);
        BUS_RST = 1'b0;
        repeat (3) @(negedge BUS_CLK);
        check("post_async_idle", 32'({ACTIVE, VETO_COUNT}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
